// File: rtl/axi4_frame_fetcher.sv
// ---------------------------------------------------------------------------
// axi4_frame_fetcher
//
// Reads one video frame from memory over an AXI4 read channel and pushes the
// returned beats into a downstream FIFO. Bursts are only requested when the
// FIFO has room for every beat already in flight plus the new burst, so the
// R channel never has to be throttled and the FIFO can never overflow.
//
// Optional feature macro: AXI_RRESP_CHECK_EN
//   defined   -> resp_err becomes sticky on any accepted beat with RRESP != OKAY
//   undefined -> RRESP is ignored and resp_err is tied low
//
// Ports
//   clk_100Mhz, rst_n      : sole clock, asynchronous active-low reset
//   frame_start/frame_base : start pulse and frame start address (IDLE only)
//   fifo_free              : free entries in the downstream FIFO
//   fifo_wr_en/_data       : FIFO write, registered one cycle after each beat
//   busy                   : high while a frame is in progress
//   frame_done             : one-cycle pulse with the last FIFO write
//   resp_err               : sticky response error flag
//   AR*/R*                 : AXI4 read address / read data channels
//   dbg_state              : current FSM state (IDLE=0, RUN=1, DRAIN=2)
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where VALID and READY are both high. Once ARVALID is raised, ARADDR and
// ARLEN stay constant and ARVALID stays high until that edge.
// ---------------------------------------------------------------------------
module axi4_frame_fetcher #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int BURST_LEN   = 64,
    parameter int FRAME_BEATS = 19200,
    parameter int MAX_OUTST   = 2,
    parameter int CNT_W       = 11
) (
    input  logic              clk_100Mhz,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [CNT_W-1:0]  fifo_free,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic              RLAST,
    output logic [1:0]        dbg_state
);

    localparam int BYTES   = DATA_W / 8;
    localparam int SIZE_L  = $clog2(BYTES);
    localparam int ALIGN_L = $clog2(BURST_LEN * BYTES);
    localparam int BEAT_W  = $clog2(FRAME_BEATS + 1);
    localparam int PEND_W  = $clog2(MAX_OUTST * BURST_LEN + 1);
    localparam int OUT_W   = $clog2(MAX_OUTST + 1);
    // Base address is aligned down to a full-burst boundary.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_L) - ADDR_W'(1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_araddr;
    logic [7:0]          r_arlen;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_wr_en;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_busy;
    logic                r_frame_done;
    logic [BEAT_W-1:0]   r_req_beats;   // beats covered by accepted ARs
    logic [BEAT_W-1:0]   r_wr_beats;    // beats written to the FIFO
    logic [PEND_W-1:0]   r_pending;     // requested but not yet written
    logic [OUT_W-1:0]    r_outst;       // accepted ARs without RLAST yet

    logic [31:0]         w_remaining;
    logic [31:0]         w_burst_beats;
    logic [31:0]         w_ar_beats;
    logic                w_can_issue;
    logic                w_ar_hs;
    logic                w_r_beat;
    logic                w_r_last;
    logic                w_last_wr;
    logic                w_req_done;
    logic [OUT_W-1:0]    w_outst_nxt;
    logic [PEND_W-1:0]   w_pend_nxt;

    assign w_remaining   = 32'(FRAME_BEATS) - 32'(r_req_beats);
    assign w_burst_beats = (w_remaining > 32'(BURST_LEN)) ? 32'(BURST_LEN) : w_remaining;
    assign w_ar_beats    = 32'(r_arlen) + 32'd1;

    // The FIFO must hold every beat already reserved plus this whole burst.
    assign w_can_issue = (r_state == S_RUN) && !r_arvalid &&
                         (32'(r_outst) < 32'(MAX_OUTST)) &&
                         (32'(fifo_free) >= 32'(r_pending) + w_burst_beats);

    assign w_ar_hs    = r_arvalid && ARREADY;
    assign w_r_beat   = RVALID && r_rready;
    assign w_r_last   = w_r_beat && RLAST;
    assign w_last_wr  = w_r_beat && (32'(r_wr_beats) == 32'(FRAME_BEATS - 1));
    assign w_req_done = w_ar_hs && ((32'(r_req_beats) + w_ar_beats) == 32'(FRAME_BEATS));

    // A new AR and a closing RLAST in the same cycle cancel out.
    always_comb begin
        w_outst_nxt = r_outst;
        if (w_ar_hs && !w_r_last) begin
            w_outst_nxt = r_outst + OUT_W'(1);
        end else if (!w_ar_hs && w_r_last) begin
            w_outst_nxt = r_outst - OUT_W'(1);
        end
    end

    assign w_pend_nxt = r_pending
                      + (w_ar_hs  ? PEND_W'(w_ar_beats) : PEND_W'(0))
                      - (w_r_beat ? PEND_W'(1)          : PEND_W'(0));

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_req_beats  <= '0;
            r_wr_beats   <= '0;
            r_pending    <= '0;
            r_outst      <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_wr_en      <= w_r_beat;
            if (w_r_beat) begin
                r_wr_data  <= RDATA;
                r_wr_beats <= r_wr_beats + BEAT_W'(1);
            end
            r_outst   <= w_outst_nxt;
            r_rready  <= (w_outst_nxt != '0);
            r_pending <= w_pend_nxt;

            if (w_ar_hs) begin
                r_arvalid   <= 1'b0;
                r_req_beats <= r_req_beats + BEAT_W'(w_ar_beats);
            end else if (w_can_issue) begin
                r_arvalid <= 1'b1;
                r_araddr  <= r_base + (ADDR_W'(r_req_beats) << SIZE_L);
                r_arlen   <= 8'(w_burst_beats - 32'd1);
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_state     <= S_RUN;
                        r_busy      <= 1'b1;
                        r_base      <= frame_base & ALIGN_MASK;
                        r_req_beats <= '0;
                        r_wr_beats  <= '0;
                        r_pending   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_req_done) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_wr) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AXI_RRESP_CHECK_EN
    logic r_resp_err;

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_err <= 1'b0;
        end else if ((r_state == S_IDLE) && frame_start) begin
            r_resp_err <= 1'b0;
        end else if (w_r_beat && (RRESP != 2'b00)) begin
            r_resp_err <= 1'b1;
        end
    end

    assign resp_err = r_resp_err;
`else
    logic w_unused_rresp;
    assign w_unused_rresp = ^RRESP;
    assign resp_err       = 1'b0;
`endif

    assign ARSIZE       = 3'(SIZE_L);
    assign ARBURST      = 2'b01;
    assign ARADDR       = r_araddr;
    assign ARLEN        = r_arlen;
    assign ARVALID      = r_arvalid;
    assign RREADY       = r_rready;
    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign dbg_state    = r_state;

endmodule

// File: doc/axi4_frame_fetcher.md
AXI4_FRAME_FETCHER -- requirements
Module: axi4_frame_fetcher

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 64, RDATA/FIFO width; power of two, 32..256.
REQ-003 SHALL have parameter BURST_LEN, default 64, beats per full burst; 1..256.
REQ-004 SHALL have parameter FRAME_BEATS, default 19200, beats per frame (320x240x16 bit at 64 bit).
REQ-005 SHALL have parameter MAX_OUTST, default 2, maximum outstanding AR bursts; 1..4.
REQ-006 SHALL have parameter CNT_W, default 11, width of fifo_free.
REQ-007 SHALL have ports: clk_100Mhz in 1, sole clock; rst_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: frame_start in 1, start-of-frame pulse; frame_base in ADDR_W, frame start address.
REQ-009 SHALL have ports: fifo_free in CNT_W, free entries of downstream FIFO; fifo_wr_en out 1; fifo_wr_data out DATA_W.
REQ-010 SHALL have ports: busy out 1; frame_done out 1, one-cycle pulse; resp_err out 1, sticky.
REQ-011 SHALL have AR ports: ARADDR out ADDR_W; ARVALID out 1; ARREADY in 1; ARLEN out 8; ARSIZE out 3; ARBURST out 2.
REQ-012 SHALL have R ports: RDATA in DATA_W; RRESP in 2; RVALID in 1; RREADY out 1; RLAST in 1.

Function
REQ-013 SHALL drive ARSIZE = log2(DATA_W/8) and ARBURST = 2'b01 (INCR) constantly.
REQ-014 SHALL implement FSM IDLE -> RUN on frame_start; RUN -> DRAIN when all FRAME_BEATS requested; DRAIN -> IDLE when all beats received.
REQ-015 SHALL, in IDLE on frame_start, latch frame_base with its low log2(BURST_LEN*DATA_W/8) bits forced to 0, and clear the beat counters.
REQ-016 SHALL ignore frame_start outside IDLE.
REQ-017 SHALL set ARLEN = min(BURST_LEN, remaining unrequested beats) - 1, so the final burst is truncated.
REQ-018 SHALL set ARADDR = latched base + requested_beats*(DATA_W/8).
REQ-019 SHALL assert ARVALID in RUN only when outstanding < MAX_OUTST and fifo_free - pending_beats >= ARLEN+1.
REQ-020 SHALL define pending_beats as beats requested but not yet written to the FIFO.
REQ-021 SHALL hold ARVALID, ARADDR and ARLEN stable until ARREADY is sampled high.
REQ-022 SHALL, on an AR handshake, increment outstanding and add ARLEN+1 to pending_beats in the same cycle.
REQ-023 SHALL drive RREADY = 1 whenever outstanding > 0, since FIFO space is pre-reserved.
REQ-024 SHALL register fifo_wr_en/fifo_wr_data one cycle after each RVALID&&RREADY beat.
REQ-025 SHALL decrement pending_beats when the write is issued.
REQ-026 SHALL decrement outstanding on an RVALID&&RREADY&&RLAST beat.
REQ-027 SHALL net an AR handshake and an RLAST beat in the same cycle, leaving outstanding unchanged.
REQ-028 SHALL pulse frame_done for one cycle on the clock edge on which the last FIFO write of a frame is issued, and return to IDLE on the same edge.
REQ-029 SHALL hold busy high in RUN and DRAIN, low in IDLE.
REQ-030 SHALL never let the FIFO overflow: with fifo_free = 0, no AR is issued and no FIFO write is issued beyond beats already reserved.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-burst, immediately force: ARVALID 0, RREADY 0, fifo_wr_en 0, busy 0, frame_done 0, resp_err 0, ARADDR 0, ARLEN 0, fifo_wr_data 0, all counters 0, FSM IDLE.
REQ-032 SHALL release reset with no AR issued until the next frame_start.

Configuration
REQ-033 SHALL, with AXI_RRESP_CHECK_EN defined, set resp_err on any accepted beat whose RRESP is not 2'b00; resp_err clears only on reset or frame_start.
REQ-034 SHALL, without AXI_RRESP_CHECK_EN, ignore RRESP and tie resp_err to 0; all other behaviour is identical.

Verification
REQ-035 SHALL cover a defaults run: frame_base=0x1000_0000, fifo_free=1024, ARREADY/RVALID always 1 -> 300 bursts with ARLEN=63, ARADDR stepping 0x200, 19200 writes, a single frame_done pulse.
REQ-036 SHALL cover truncation: FRAME_BEATS=100, BURST_LEN=64 -> ARLEN 63 then 35, final ARADDR base+0x200, 100 writes.
REQ-037 SHALL cover backpressure: fifo_free held at 63 -> no ARVALID; raise to 64 -> exactly one AR issued, and no second AR while pending_beats=64.
REQ-038 SHALL cover outstanding: MAX_OUTST=2, RVALID delayed 50 cycles -> exactly 2 ARs accepted, then ARVALID low until the first RLAST.
REQ-039 SHALL cover reset mid-burst: rst_n low at beat 20 of burst 3 -> all outputs 0 within the same cycle; after release plus frame_start, ARADDR=base.
REQ-040 SHALL cover RRESP checking: with the macro defined, RRESP=2'b10 on beat 5 -> resp_err=1 held to end of frame; without the macro -> resp_err stays 0.
